// File: rtl/float_adder_rr_arbiter.sv
// Round-robin front end that shares one fixed-latency pipelined float adder between
// NUM_REQ requesters. A requester-ID tag follows each issue so that the sum is returned to its owner.
module float_adder_rr_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ADD_LATENCY = 5,
    localparam int ID_W       = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1,
    localparam int CNT_W      = $clog2(ADD_LATENCY + 3)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NUM_REQ-1:0]    req_valid_i,
    output logic [NUM_REQ-1:0]    req_ready_o,
    input  logic [NUM_REQ*32-1:0] req_a_i,
    input  logic [NUM_REQ*32-1:0] req_b_i,
    output logic [NUM_REQ-1:0]    resp_valid_o,
    output logic [31:0]           resp_sum_o,
    output logic                  adder_issue_o,
    output logic [31:0]           adder_a_o,
    output logic [31:0]           adder_b_o,
    input  logic                  adder_ready_i,
    input  logic [31:0]           adder_sum_i,
    output logic [ID_W-1:0]       grant_id_o,
    output logic [CNT_W-1:0]      inflight_o
);

    logic [ID_W-1:0]                rr_ptr;
    logic [ID_W-1:0]                winner;
    logic [ID_W-1:0]                scan_idx;
    logic                           found;
    logic                           grant;
    logic                           ret;
    logic [31:0]                    win_a;
    logic [31:0]                    win_b;
    logic [ADD_LATENCY:0]           tag_vld;
    logic [ADD_LATENCY:0][ID_W-1:0] tag_id;

    // Scan from the pointer upward with wrap; the first valid requester wins.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        scan_idx = rr_ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid_i[scan_idx]) begin
                found  = 1'b1;
                winner = scan_idx;
            end
            scan_idx = (scan_idx == ID_W'(NUM_REQ - 1)) ? '0 : scan_idx + ID_W'(1);
        end
    end

    assign grant       = found && adder_ready_i && !rst_i;
    assign req_ready_o = grant ? (NUM_REQ'(1) << winner) : '0;
    assign win_a       = req_a_i[32*winner +: 32];
    assign win_b       = req_b_i[32*winner +: 32];
    assign ret         = |resp_valid_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr        <= '0;
            grant_id_o    <= '0;
            adder_issue_o <= 1'b0;
            adder_a_o     <= '0;
            adder_b_o     <= '0;
        end else begin
            adder_issue_o <= grant;
            if (grant) begin
                rr_ptr     <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);
                grant_id_o <= winner;
                adder_a_o  <= win_a;
                adder_b_o  <= win_b;
            end
        end
    end

    // The adder never stalls, so the tag shadow pipeline shifts every cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tag_vld <= '0;
            tag_id  <= '0;
        end else begin
            tag_vld <= {tag_vld[ADD_LATENCY-1:0], grant};
            tag_id  <= {tag_id[ADD_LATENCY-1:0], winner};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            resp_valid_o <= '0;
            resp_sum_o   <= '0;
        end else if (tag_vld[ADD_LATENCY]) begin
            resp_valid_o <= NUM_REQ'(1) << tag_id[ADD_LATENCY];
            resp_sum_o   <= adder_sum_i;
        end else begin
            resp_valid_o <= '0;
        end
    end

    // An operation counts as in flight until the cycle its response pulse is visible.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            inflight_o <= '0;
        end else begin
            case ({grant, ret})
                2'b10:   inflight_o <= inflight_o + CNT_W'(1);
                2'b01:   inflight_o <= inflight_o - CNT_W'(1);
                default: inflight_o <= inflight_o;
            endcase
        end
    end

endmodule

// File: doc/float_adder_rr_arbiter.md
Name: float_adder_rr_arbiter

Overview:
- Shares one fixed-latency pipelined float adder between NUM_REQ requesters.
- Each requester presents an IEEE-754 single-precision operand pair on a valid/ready handshake. Grants are round-robin, at most one issue per cycle.
- Each issued operation carries a requester-ID tag down a shadow pipeline. The sum is returned to the originating requester exactly ADD_LATENCY+2 cycles after acceptance.
- Sits between client blocks (e.g. vector accumulators) and the adder core.

Parameters:
- NUM_REQ, 4, number of requesters (2..16). ID_W = max(1, clog2(NUM_REQ)) is derived.
- ADD_LATENCY, 5, cycles from adder_issue_o high to the matching adder_sum_i being valid (>=1).

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- req_valid_i  in  NUM_REQ  per-requester operand pair valid.
- req_ready_o  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a_i  in  NUM_REQ*32  operand A, requester k at bits [32k+31:32k].
- req_b_i  in  NUM_REQ*32  operand B, same packing.
- resp_valid_o  out  NUM_REQ  one-cycle pulse; one-hot or zero.
- resp_sum_o  out  32  result, valid for the requester flagged in resp_valid_o.
- adder_issue_o  out  1  operands valid to adder this cycle.
- adder_a_o  out  32  operand A to adder.
- adder_b_o  out  32  operand B to adder.
- adder_ready_i  in  1  high in cycle T means the adder can take an issue in T+1.
- adder_sum_i  in  32  adder result.
- grant_id_o  out  ID_W  ID of the last granted requester.
- inflight_o  out  clog2(ADD_LATENCY+3)  operations accepted but not yet returned.

Behaviour:

Reset (async, while rst_i high):
- All registers clear: adder_issue_o=0, adder_a_o=0, adder_b_o=0, resp_valid_o=0, resp_sum_o=0, grant_id_o=0, inflight_o=0.
- RR pointer=0, tag pipeline all invalid.
- req_ready_o is forced to 0 while rst_i is high.
- Reset mid-operation discards all in-flight tags. No response is produced for them, and adder results arriving after reset release are ignored because their tags are invalid.

Arbitration (combinational, cycle T):
- Candidate set = req_valid_i, gated by adder_ready_i.
- Winner = first set bit scanning from pointer upward, wrapping at NUM_REQ-1 -> 0.
- req_ready_o[winner]=1; all other bits 0.
- If adder_ready_i=0 or no valid requester, req_ready_o=0.

Accept (edge ending cycle T, when a grant occurs):
- pointer <= (winner+1) mod NUM_REQ; grant_id_o <= winner.
- adder_issue_o <= 1; adder_a_o/adder_b_o <= winner's operands.
- Tag stage 0 <= {1, winner}.
- With no grant: adder_issue_o <= 0, pointer and grant_id_o hold, adder_a_o/adder_b_o hold, tag stage 0 <= invalid.

Requester obligations:
- Requesters may drop valid or change operands freely. Only the cycle with valid && ready is a transfer.

Tag pipeline:
- ADD_LATENCY+1 stages, shifting every cycle unconditionally; the adder is fixed-latency and never stalls in-flight work.
- An issue in cycle T+1 reaches the last stage in cycle T+1+ADD_LATENCY, when adder_sum_i is valid.

Return (edge ending that cycle):
- If the last-stage tag is valid: resp_valid_o <= onehot(id), resp_sum_o <= adder_sum_i.
- Otherwise resp_valid_o <= 0 and resp_sum_o holds.
- Total latency from acceptance cycle T to resp_valid_o high: ADD_LATENCY+2 cycles.
- No response backpressure; requesters must sink results.

inflight_o:
- +1 on accept, -1 on return.
- Both in the same cycle -> unchanged.
- Maximum value is ADD_LATENCY+2; the counter never wraps.

Throughput and ordering:
- Throughput is 1 op/cycle when adder_ready_i stays high.
- Responses return in issue order.
- Back-to-back accepts from the same requester are allowed whenever it is the sole valid requester.

Test Plan:
- Single op: NUM_REQ=4, ADD_LATENCY=5, bench adder model. req 2 presents A=0x3F800000 (1.0), B=0x40000000 (2.0) at cycle 10 with ready_i high -> req_ready_o=4'b0100 at cycle 10; adder_issue_o=1 with those operands at cycle 11; resp_valid_o=4'b0100, resp_sum_o=0x40400000 (3.0) at cycle 17; inflight_o 1 during cycles 11..17, 0 after.
- Fairness: all four valid continuously for 8 cycles, pointer starting at 0 -> grant order 0,1,2,3,0,1,2,3; responses return in the same order, one per cycle, 7 cycles after each accept.
- Wrap/skip: pointer=3, only req 1 and req 3 valid -> req 3 granted first, then req 1, then req 3.
- Adder stall: adder_ready_i low for 3 cycles with req 0 valid -> req_ready_o=0 and adder_issue_o=0 for those cycles; responses already in flight still return on schedule; a grant resumes the cycle adder_ready_i returns high.
- Mid-operation reset: three ops in flight, rst_i pulsed asynchronously between clock edges -> all outputs 0 immediately, inflight_o=0; no resp_valid_o pulses afterwards even though the adder model still emits sums.
- Simultaneous accept/return: steady single-requester stream -> inflight_o stays at 7 (ADD_LATENCY+2) from steady state on, never exceeding it.
